// File: rtl/cmp_result_tracker.sv
// cmp_result_tracker: decodes comparator result codes, keeps saturating
// per-relation counters and reports stable runs of one relation.
module cmp_result_tracker #(
    parameter int STABLE_LEN = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmp_valid,
    input  logic [7:0]       cmp_code,
    input  logic             clear,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       last_rel,
    output logic             stable,
    output logic             change_pulse
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRACK,
        S_STABLE
    } state_t;

    localparam logic [3:0]       LP_LEN = 4'(STABLE_LEN);
    localparam bit               LP_ONE = (STABLE_LEN == 1);
    localparam logic [CNT_W-1:0] LP_INC = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_MAX = '1;

    state_t           r_state;
    logic [3:0]       r_run;
    logic [1:0]       r_rel;
    logic             r_stable;
    logic             r_pulse;
    logic [CNT_W-1:0] r_gt;
    logic [CNT_W-1:0] r_eq;
    logic [CNT_W-1:0] r_lt;
    logic [CNT_W-1:0] r_err;

    logic [1:0]       w_rel;
    logic             w_inv;
    logic [3:0]       w_run_inc;

    assign w_run_inc = r_run + 4'd1;

    // Exact 8-bit decode of the result code; anything else is malformed
    always_comb begin
        w_rel = 2'b00;
        w_inv = 1'b1;
        case (cmp_code)
            8'hFF: begin w_rel = 2'b11; w_inv = 1'b0; end
            8'h0F: begin w_rel = 2'b10; w_inv = 1'b0; end
            8'h00: begin w_rel = 2'b01; w_inv = 1'b0; end
            default: ;
        endcase
    end

    // Saturating event counters, one per decoded relation plus errors
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gt  <= '0;
            r_eq  <= '0;
            r_lt  <= '0;
            r_err <= '0;
        end else if (clear) begin
            r_gt  <= '0;
            r_eq  <= '0;
            r_lt  <= '0;
            r_err <= '0;
        end else if (cmp_valid) begin
            if (w_inv) begin
                if (r_err != LP_MAX) r_err <= r_err + LP_INC;
            end else begin
                case (w_rel)
                    2'b11: if (r_gt != LP_MAX) r_gt <= r_gt + LP_INC;
                    2'b10: if (r_eq != LP_MAX) r_eq <= r_eq + LP_INC;
                    default: if (r_lt != LP_MAX) r_lt <= r_lt + LP_INC;
                endcase
            end
        end
    end

    // Run-length FSM with registered stable flag and change pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_run    <= 4'd0;
            r_rel    <= 2'b00;
            r_stable <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (clear) begin
                r_state  <= S_IDLE;
                r_run    <= 4'd0;
                r_rel    <= 2'b00;
                r_stable <= 1'b0;
            end else if (cmp_valid) begin
                if (w_inv) begin
                    r_state  <= S_IDLE;
                    r_run    <= 4'd0;
                    r_rel    <= 2'b00;
                    r_stable <= 1'b0;
                end else begin
                    case (r_state)
                        S_IDLE: begin
                            r_rel    <= w_rel;
                            r_run    <= 4'd1;
                            r_state  <= LP_ONE ? S_STABLE : S_TRACK;
                            r_stable <= LP_ONE;
                        end
                        S_TRACK, S_STABLE: begin
                            if (w_rel == r_rel) begin
                                if (r_run < LP_LEN) begin
                                    r_run <= w_run_inc;
                                    if (w_run_inc == LP_LEN) begin
                                        r_state  <= S_STABLE;
                                        r_stable <= 1'b1;
                                    end
                                end
                            end else begin
                                r_rel    <= w_rel;
                                r_run    <= 4'd1;
                                r_pulse  <= 1'b1;
                                r_state  <= LP_ONE ? S_STABLE : S_TRACK;
                                r_stable <= LP_ONE;
                            end
                        end
                        default: begin
                            r_state  <= S_IDLE;
                            r_run    <= 4'd0;
                            r_rel    <= 2'b00;
                            r_stable <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign gt_cnt       = r_gt;
    assign eq_cnt       = r_eq;
    assign lt_cnt       = r_lt;
    assign err_cnt      = r_err;
    assign last_rel     = r_rel;
    assign stable       = r_stable;
    assign change_pulse = r_pulse;

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Scoreboard bench for cmp_result_tracker: a STABLE_LEN=4 and a
// STABLE_LEN=1 instance share stimulus; a monitor checks each cycle.
module tb_cmp_result_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmp_valid = 1'b0;
    logic [7:0] cmp_code = 8'h00;
    logic       clear = 1'b0;

    logic [7:0] a_gt, a_eq, a_lt, a_err;
    logic [1:0] a_rel;
    logic       a_stb, a_pls;
    logic [7:0] b_gt, b_eq, b_lt, b_err;
    logic [1:0] b_rel;
    logic       b_stb, b_pls;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    cmp_result_tracker #(.STABLE_LEN(4), .CNT_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .cmp_valid(cmp_valid),
        .cmp_code(cmp_code), .clear(clear),
        .gt_cnt(a_gt), .eq_cnt(a_eq), .lt_cnt(a_lt), .err_cnt(a_err),
        .last_rel(a_rel), .stable(a_stb), .change_pulse(a_pls)
    );

    cmp_result_tracker #(.STABLE_LEN(1), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .cmp_valid(cmp_valid),
        .cmp_code(cmp_code), .clear(clear),
        .gt_cnt(b_gt), .eq_cnt(b_eq), .lt_cnt(b_lt), .err_cnt(b_err),
        .last_rel(b_rel), .stable(b_stb), .change_pulse(b_pls)
    );

    typedef struct {
        logic [7:0] gt, eq, lt, er;
        logic [1:0] rel;
        logic       stb, pls;
        int         run;
    } mdl_t;

    typedef struct {
        mdl_t a;
        mdl_t b;
    } exp_t;

    exp_t q[$];
    mdl_t ma, mb;

    wire [35:0] w_a = {a_gt, a_eq, a_lt, a_err, a_rel, a_stb, a_pls};
    wire [35:0] w_b = {b_gt, b_eq, b_lt, b_err, b_rel, b_stb, b_pls};

    function automatic logic [35:0] pk(mdl_t m);
        return {m.gt, m.eq, m.lt, m.er, m.rel, m.stb, m.pls};
    endfunction

    function automatic logic [7:0] sat(logic [7:0] x);
        return (x == 8'hFF) ? x : x + 8'd1;
    endfunction

    function automatic mdl_t zero();
        mdl_t z;
        z.gt = 0; z.eq = 0; z.lt = 0; z.er = 0;
        z.rel = 0; z.stb = 0; z.pls = 0; z.run = 0;
        return z;
    endfunction

    // Behavioural reference: run==0 means no current relation
    function automatic mdl_t step_m(mdl_t m, bit v, bit c,
                                    logic [7:0] code, int sl);
        mdl_t n = m;
        logic [1:0] r;
        n.pls = 0;
        if (c) return zero();
        if (!v) return n;
        r = (code == 8'hFF) ? 2'd3 :
            (code == 8'h0F) ? 2'd2 :
            (code == 8'h00) ? 2'd1 : 2'd0;
        if (r == 0) begin
            n.er = sat(m.er);
            n.rel = 0; n.run = 0; n.stb = 0;
            return n;
        end
        if (r == 3) n.gt = sat(m.gt);
        if (r == 2) n.eq = sat(m.eq);
        if (r == 1) n.lt = sat(m.lt);
        if (m.run == 0) begin
            n.rel = r; n.run = 1;
        end else if (r != m.rel) begin
            n.rel = r; n.run = 1; n.pls = 1;
        end else if (m.run < sl) begin
            n.run = m.run + 1;
        end
        n.stb = (n.run == sl);
        return n;
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // One clock of stimulus; expectation is queued after the edge
    task automatic step(bit v, bit c, logic [7:0] code);
        exp_t e;
        cmp_valid = v;
        clear = c;
        cmp_code = code;
        @(posedge clk);
        ma = step_m(ma, v, c, code, 4);
        mb = step_m(mb, v, c, code, 1);
        e.a = ma;
        e.b = mb;
        q.push_back(e);
        #1;
    endtask

    task automatic rep(int n, logic [7:0] code);
        for (int i = 0; i < n; i++) step(1, 0, code);
    endtask

    // Monitor: compares registered outputs away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("seq_len4", 64'(w_a), 64'(pk(e.a)));
                check("seq_len1", 64'(w_b), 64'(pk(e.b)));
            end
        end
    end

    initial begin
        ma = zero();
        mb = zero();
        #12;
        check("reset_a", 64'(w_a), 64'd0);
        check("reset_b", 64'(w_b), 64'd0);
        rst_n = 1'b1;
        #5;

        // Four GT back to back
        rep(3, 8'hFF);
        check("stb_before_4th", 64'(a_stb), 64'd0);
        step(1, 0, 8'hFF);
        check("gt4_cnt", 64'(a_gt), 64'd4);
        check("gt4_rel", 64'(a_rel), 64'd3);
        check("gt4_stb", 64'(a_stb), 64'd1);
        check("gt4_pls", 64'(a_pls), 64'd0);

        // GT, GT, EQ with gaps
        step(0, 1, 8'h00);
        step(1, 0, 8'hFF);
        step(0, 0, 8'h0F);
        step(1, 0, 8'hFF);
        step(0, 0, 8'h0F);
        step(0, 0, 8'h0F);
        step(1, 0, 8'h0F);
        check("gap_pls", 64'(a_pls), 64'd1);
        check("gap_rel", 64'(a_rel), 64'd2);
        check("gap_cnts", 64'({a_gt, a_eq, a_stb}), 64'({8'd2, 8'd1, 1'b0}));
        step(0, 0, 8'h0F);
        check("gap_pls_gone", 64'(a_pls), 64'd0);

        // Four LT, invalid, LT again
        step(0, 1, 8'h00);
        rep(4, 8'h00);
        check("lt_stb", 64'(a_stb), 64'd1);
        step(1, 0, 8'h3C);
        check("inv_state", 64'({a_err, a_stb, a_rel}), 64'({8'd1, 1'b0, 2'b00}));
        step(1, 0, 8'h00);
        check("after_inv", 64'({a_lt, a_pls, a_rel}), 64'({8'd5, 1'b0, 2'b01}));
        step(1, 0, 8'h0E);
        step(1, 0, 8'h1F);
        check("near_codes", 64'(a_err), 64'd3);

        // Saturation
        step(0, 1, 8'h00);
        rep(300, 8'h0F);
        check("eq_sat", 64'({a_eq, a_stb}), 64'({8'd255, 1'b1}));
        rep(300, 8'hFF);
        check("gt_sat", 64'({a_gt, a_eq}), 64'({8'd255, 8'd255}));

        // Clear beats a simultaneous sample
        step(0, 1, 8'h00);
        rep(3, 8'hFF);
        check("pre_clr", 64'(a_gt), 64'd3);
        step(1, 1, 8'hFF);
        check("clr_all", 64'(w_a), 64'd0);
        step(1, 0, 8'hFF);
        check("clr_restart", 64'({a_gt, a_rel, a_pls}), 64'({8'd1, 2'b11, 1'b0}));

        // Asynchronous reset while stable
        rep(3, 8'hFF);
        check("pre_rst_stb", 64'(a_stb), 64'd1);
        step(0, 0, 8'hFF);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_a", 64'(w_a), 64'd0);
        check("async_rst_b", 64'(w_b), 64'd0);
        ma = zero();
        mb = zero();
        #1;
        rst_n = 1'b1;

        // Single-sample stability on the STABLE_LEN=1 instance
        step(0, 1, 8'h00);
        step(1, 0, 8'h00);
        check("one_lt", 64'({b_stb, b_pls, b_rel}), 64'({1'b1, 1'b0, 2'b01}));
        step(1, 0, 8'hFF);
        check("one_gt", 64'({b_stb, b_pls, b_rel}), 64'({1'b1, 1'b1, 2'b11}));
        step(0, 0, 8'hFF);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        n_tot++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
